// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: STAGES segments of WIDTH/STAGES bits, one segment per stage.
// Optional signed-overflow output enabled by defining CLA_PIPE_ADDER_OVF_EN.
module cla_pipe_adder #(
  parameter int WIDTH  = 256,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready
`ifdef CLA_PIPE_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;
  localparam int NG  = SEG / 4;        // 4-bit groups per segment
  localparam int NB  = (NG + 3) / 4;   // blocks of four groups per segment

  logic [STAGES-1:0] valid_vec;
  logic              advance;

  // A stalled full pipe freezes every stage; otherwise everything shifts.
  assign advance   = !valid_vec[STAGES-1] | out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_vec[STAGES-1];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = gi * SEG;
      localparam int RW = WIDTH - LO;  // operand bits not yet summed

      logic [RW-1:0]     a_cur, b_cur;
      logic              c_cur, v_cur;
      logic [SEG-1:0]    p, g, c, seg_sum;
      logic [NB*4-1:0]   gp, gg;
      logic [NG-1:0]     gc;
      logic [NB-1:0]     bp, bg;
      logic [NB:0]       bc;
      logic              seg_co;
      logic [LO+SEG-1:0] sum_next;
      logic [LO+SEG-1:0] sum_reg;
      logic              carry_reg, valid_reg;

      if (gi == 0) begin : g_first
        assign a_cur    = din1;
        assign b_cur    = din2;
        assign c_cur    = cin;
        assign v_cur    = in_valid;
        assign sum_next = seg_sum;
      end else begin : g_next
        assign a_cur    = g_stage[gi-1].g_ops.opa_reg;
        assign b_cur    = g_stage[gi-1].g_ops.opb_reg;
        assign c_cur    = g_stage[gi-1].carry_reg;
        assign v_cur    = g_stage[gi-1].valid_reg;
        assign sum_next = {seg_sum, g_stage[gi-1].sum_reg};
      end

      // Two-level lookahead: groups of 4 bits, blocks of 4 groups; padded groups pass carry through.
      always_comb begin
        p  = a_cur[SEG-1:0] ^ b_cur[SEG-1:0];
        g  = a_cur[SEG-1:0] & b_cur[SEG-1:0];
        gp = '1;
        gg = '0;
        gc = '0;
        c  = '0;
        bp = '0;
        bg = '0;
        for (int j = 0; j < NG; j++) begin
          gp[j] = &p[4*j +: 4];
          gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                | (&p[4*j+1 +: 3] & g[4*j]);
        end
        bc[0] = c_cur;
        for (int k = 0; k < NB; k++) begin
          bp[k]   = &gp[4*k +: 4];
          bg[k]   = gg[4*k+3] | (gp[4*k+3] & gg[4*k+2]) | (gp[4*k+3] & gp[4*k+2] & gg[4*k+1])
                  | (&gp[4*k+1 +: 3] & gg[4*k]);
          bc[k+1] = bg[k] | (bp[k] & bc[k]);
        end
        for (int j = 0; j < NG; j++) begin
          case (j % 4)
            0:       gc[j] = bc[j/4];
            1:       gc[j] = gg[j-1] | (gp[j-1] & bc[j/4]);
            2:       gc[j] = gg[j-1] | (gp[j-1] & gg[j-2]) | (gp[j-1] & gp[j-2] & bc[j/4]);
            default: gc[j] = gg[j-1] | (gp[j-1] & gg[j-2]) | (gp[j-1] & gp[j-2] & gg[j-3])
                           | (gp[j-1] & gp[j-2] & gp[j-3] & bc[j/4]);
          endcase
        end
        for (int j = 0; j < NG; j++) begin
          c[4*j]   = gc[j];
          c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
          c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
          c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                   | (&p[4*j +: 3] & gc[j]);
        end
        seg_sum = p ^ c;
        seg_co  = bc[NB];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_reg   <= '0;
          carry_reg <= 1'b0;
          valid_reg <= 1'b0;
        end else if (advance) begin
          sum_reg   <= sum_next;
          carry_reg <= seg_co;
          valid_reg <= v_cur;
        end
      end

      assign valid_vec[gi] = valid_reg;

      if (gi < STAGES-1) begin : g_ops
        logic [RW-SEG-1:0] opa_reg, opb_reg;

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            opa_reg <= '0;
            opb_reg <= '0;
          end else if (advance) begin
            opa_reg <= a_cur[RW-1:SEG];
            opb_reg <= b_cur[RW-1:SEG];
          end
        end
      end else begin : g_out
        assign dout = sum_reg;
        assign cout = carry_reg;
`ifdef CLA_PIPE_ADDER_OVF_EN
        logic ovf_reg;

        // Same-sign operands with a differently signed result overflowed.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            ovf_reg <= 1'b0;
          end else if (advance) begin
            ovf_reg <= (a_cur[SEG-1] == b_cur[SEG-1]) && (seg_sum[SEG-1] != a_cur[SEG-1]);
          end
        end

        assign ovf = ovf_reg;
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and random checks of cla_pipe_adder at (256,4), (256,8) and (64,1), with a
// scoreboard checking value, order and latency of every result.
module tb_cla_pipe_adder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [255:0] din1, din2;
  logic         cin, in_valid, out_ready;

  logic         in_ready4, out_valid4, cout4;
  logic [255:0] dout4;
  logic         in_ready8, out_valid8, cout8;
  logic [255:0] dout8;
  logic         in_ready1, out_valid1, cout1;
  logic [63:0]  dout1;
`ifdef CLA_PIPE_ADDER_OVF_EN
  logic         ovf4, ovf8, ovf1;
`endif

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(256), .STAGES(4)) dut4 (
    .clk(clk), .rst(rst), .din1(din1), .din2(din2), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready4), .dout(dout4), .cout(cout4),
    .out_valid(out_valid4), .out_ready(out_ready)
`ifdef CLA_PIPE_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  cla_pipe_adder #(.WIDTH(256), .STAGES(8)) dut8 (
    .clk(clk), .rst(rst), .din1(din1), .din2(din2), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready8), .dout(dout8), .cout(cout8),
    .out_valid(out_valid8), .out_ready(out_ready)
`ifdef CLA_PIPE_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  cla_pipe_adder #(.WIDTH(64), .STAGES(1)) dut1 (
    .clk(clk), .rst(rst), .din1(din1[63:0]), .din2(din2[63:0]), .cin(cin),
    .in_valid(in_valid), .in_ready(in_ready1), .dout(dout1), .cout(cout1),
    .out_valid(out_valid1), .out_ready(out_ready)
`ifdef CLA_PIPE_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );

  typedef struct {
    logic [256:0] v;
    logic         o;
    int           t;
    bit           lc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   lat_on = 1'b1;

  task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int w = 0; w < 8; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // {carry, sum} of an unsigned w-bit addition
  function automatic logic [256:0] usum(input logic [255:0] a, input logic [255:0] b,
                                        input logic ci, input int w);
    logic [64:0]  s65;
    logic [256:0] s257;
    if (w == 64) begin
      s65 = {1'b0, a[63:0]} + {1'b0, b[63:0]} + 65'(ci);
      return {192'b0, s65};
    end
    s257 = {1'b0, a} + {1'b0, b} + 257'(ci);
    return s257;
  endfunction

  // Signed overflow: the sign-extended exact sum does not fit in w bits
  function automatic logic sovf(input logic [255:0] a, input logic [255:0] b,
                                input logic ci, input int w);
    logic [256:0] sa, sb, r;
    if (w == 64) begin
      sa = {{193{a[63]}}, a[63:0]};
      sb = {{193{b[63]}}, b[63:0]};
    end else begin
      sa = {a[255], a};
      sb = {b[255], b};
    end
    r = sa + sb + 257'(ci);
    return r[w] ^ r[w-1];
  endfunction

  task automatic retire(input int id, input logic [256:0] obs, input logic obs_o);
    exp_t  e;
    int    n, lat;
    string nm;
    case (id)
      0:       begin n = q4.size(); lat = 4; nm = "d4"; end
      1:       begin n = q8.size(); lat = 8; nm = "d8"; end
      default: begin n = q1.size(); lat = 1; nm = "d1"; end
    endcase
    chk({nm, "_spurious_valid"}, 257'(n == 0), 257'(0));
    if (n == 0) return;
    case (id)
      0:       e = q4.pop_front();
      1:       e = q8.pop_front();
      default: e = q1.pop_front();
    endcase
    chk({nm, "_sum"}, obs, e.v);
`ifdef CLA_PIPE_ADDER_OVF_EN
    chk({nm, "_ovf"}, 257'(obs_o), 257'(e.o));
`endif
    if (e.lc) chk({nm, "_latency"}, 257'(cyc - e.t), 257'(lat));
    $display("%s out cout_sum=%h ovf=%0d lat=%0d", nm, obs, obs_o, cyc - e.t);
  endtask

  task automatic run_cycle(input bit iv, input logic [255:0] a, input logic [255:0] b,
                           input logic ci, input bit ordy, input bit hand_en,
                           input logic [256:0] hand_v, input logic hand_o, output bit acc4);
    exp_t e;
    logic o4, o8, o1;
    in_valid  = iv;
    din1      = a;
    din2      = b;
    cin       = ci;
    out_ready = ordy;
    #1;
`ifdef CLA_PIPE_ADDER_OVF_EN
    o4 = ovf4; o8 = ovf8; o1 = ovf1;
`else
    o4 = 1'b0; o8 = 1'b0; o1 = 1'b0;
`endif
    if (out_valid4 && out_ready) retire(0, {cout4, dout4}, o4);
    if (out_valid8 && out_ready) retire(1, {cout8, dout8}, o8);
    if (out_valid1 && out_ready) retire(2, 257'({cout1, dout1}), o1);
    acc4 = iv && in_ready4;
    e.t  = cyc;
    e.lc = lat_on;
    if (acc4) begin
      e.v = hand_en ? hand_v : usum(a, b, ci, 256);
      e.o = hand_en ? hand_o : sovf(a, b, ci, 256);
      q4.push_back(e);
    end
    if (iv && in_ready8) begin
      e.v = usum(a, b, ci, 256);
      e.o = sovf(a, b, ci, 256);
      q8.push_back(e);
    end
    if (iv && in_ready1) begin
      e.v = usum(a, b, ci, 64);
      e.o = sovf(a, b, ci, 64);
      q1.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    run_cycle(1'b0, '0, '0, 1'b0, ordy, 1'b0, '0, 1'b0, acc);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_d4_left"}, 257'(q4.size()), 257'(0));
    chk({tag, "_d8_left"}, 257'(q8.size()), 257'(0));
    chk({tag, "_d1_left"}, 257'(q1.size()), 257'(0));
  endtask

  initial begin
    logic [255:0] ones, msb, maxpos;
    logic [255:0] sa[10];
    logic [255:0] sb[10];
    logic         sc[10];
    bit           acc, iv, ordy;
    int           k;

    ones      = '1;
    msb       = ones << 255;
    maxpos    = ones >> 1;
    in_valid  = 1'b0;
    din1      = '0;
    din2      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    rst       = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid4", 257'(out_valid4), 257'(0));
    chk("rst_dout4", 257'(dout4), 257'(0));
    chk("rst_cout4", 257'(cout4), 257'(0));
    chk("rst_in_ready4", 257'(in_ready4), 257'(1));
    chk("rst_out_valid8", 257'(out_valid8), 257'(0));
    chk("rst_out_valid1", 257'(out_valid1), 257'(0));
`ifdef CLA_PIPE_ADDER_OVF_EN
    chk("rst_ovf4", 257'(ovf4), 257'(0));
`endif
    rst = 1'b0;

    // All ones + 1 wraps to zero with carry out
    run_cycle(1'b1, ones, 256'd1, 1'b0, 1'b1, 1'b1, {1'b1, 256'b0}, 1'b0, acc);
    chk("wrap_accept", 257'(acc), 257'(1));
    repeat (6) idle(1'b1);

    // Carry-in alone, then two MSBs, then max positive + 1, back to back
    run_cycle(1'b1, '0, '0, 1'b1, 1'b1, 1'b1, 257'd1, 1'b0, acc);
    run_cycle(1'b1, msb, msb, 1'b0, 1'b1, 1'b1, {1'b1, 256'b0}, 1'b1, acc);
    run_cycle(1'b1, maxpos, 256'd1, 1'b0, 1'b1, 1'b1, {1'b0, msb}, 1'b1, acc);
    repeat (10) idle(1'b1);
    chk_empty("directed");

    // Ten back-to-back operand sets with out_ready low for stream cycles 5..7
    for (int i = 0; i < 10; i++) begin
      sa[i] = rnd256();
      sb[i] = rnd256();
      sc[i] = 1'($urandom_range(0, 1));
    end
    lat_on = 1'b0;
    k = 0;
    for (int cc = 0; cc < 40 && k < 10; cc++) begin
      ordy = !(cc >= 5 && cc <= 7);
      run_cycle(1'b1, sa[k], sb[k], sc[k], ordy, 1'b0, '0, 1'b0, acc);
      if (cc < 5) chk("stream_accept", 257'(acc), 257'(1));
      else if (cc <= 7) chk("stall_in_ready", 257'(acc), 257'(0));
      if (acc) k++;
    end
    chk("stream_count", 257'(k), 257'(10));
    repeat (12) idle(1'b1);
    chk_empty("stream");

    // Reset with three results in flight, oldest stalled at the output
    for (int i = 0; i < 3; i++)
      run_cycle(1'b1, rnd256(), rnd256(), 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0, acc);
    idle(1'b0);
    chk("prerst_out_valid4", 257'(out_valid4), 257'(1));
    rst = 1'b1;
    #1;
    chk("midrst_out_valid4", 257'(out_valid4), 257'(0));
    chk("midrst_dout4", 257'(dout4), 257'(0));
    chk("midrst_cout4", 257'(cout4), 257'(0));
    chk("midrst_in_ready4", 257'(in_ready4), 257'(1));
    chk("midrst_out_valid8", 257'(out_valid8), 257'(0));
    chk("midrst_out_valid1", 257'(out_valid1), 257'(0));
    q4.delete();
    q8.delete();
    q1.delete();
    @(posedge clk);
    #1;
    cyc++;
    rst    = 1'b0;
    lat_on = 1'b1;
    repeat (12) idle(1'b1);
    chk_empty("after_rst");

    // Random sweep: latency checked while out_ready is held high, then random backpressure
    for (int n = 0; n < 1000; n++) begin
      iv     = $urandom_range(0, 9) < 8;
      ordy   = (n < 600) ? 1'b1 : ($urandom_range(0, 3) != 0);
      lat_on = (n < 590);
      run_cycle(iv, rnd256(), rnd256(), 1'($urandom_range(0, 1)), ordy, 1'b0, '0, 1'b0, acc);
    end
    lat_on = 1'b1;
    repeat (12) idle(1'b1);
    chk_empty("sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
